rpc_wbuf_burst_drainer: RTL and testbench

//  Read-side consumer of the SRAM-backed write-data buffer FIFO.
//  - Accepts a burst command and waits until the buffer holds the whole burst.
//  - Pops exactly that many words through the FIFO read handshake.
//  - Streams them to the RPC PHY write path through a registered output stage, tagging the final word.
//  - Guarantees the PHY never sees a mid-burst underrun caused by an incomplete buffer.

---
 rtl/rpc_wbuf_burst_drainer_if.sv | 33 +++
 rtl/rpc_wbuf_burst_drainer.sv | 126 ++++++++++++
 tb/tb_rpc_wbuf_burst_drainer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rpc_wbuf_burst_drainer_if.sv
// Handshake bundle between the write-buffer burst drainer, its command source,
// the SRAM buffer read port and the RPC PHY write path.
interface rpc_wbuf_burst_drainer_if #(
  parameter int DataWidth  = 256,
  parameter int LenWidth   = 6,
  parameter int UsageWidth = 9
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [LenWidth-1:0]   cmd_len_i;
  logic [UsageWidth-1:0] usage_i;
  logic                  fifo_valid_i;
  logic                  fifo_ready_o;
  logic [DataWidth-1:0]  fifo_data_i;
  logic                  phy_valid_o;
  logic                  phy_ready_i;
  logic [DataWidth-1:0]  phy_data_o;
  logic                  phy_last_o;
  logic                  busy_o;
  logic                  done_o;

  // Drainer side
  modport slave (
    input  cmd_valid_i, cmd_len_i, usage_i, fifo_valid_i, fifo_data_i, phy_ready_i,
    output cmd_ready_o, fifo_ready_o, phy_valid_o, phy_data_o, phy_last_o, busy_o, done_o
  );

  // Environment side (command source, buffer, PHY)
  modport master (
    output cmd_valid_i, cmd_len_i, usage_i, fifo_valid_i, fifo_data_i, phy_ready_i,
    input  cmd_ready_o, fifo_ready_o, phy_valid_o, phy_data_o, phy_last_o, busy_o, done_o
  );
endinterface

// File: rtl/rpc_wbuf_burst_drainer.sv
// Drains one complete burst from the write-data buffer to the RPC PHY, waiting
// until the whole burst is buffered so the PHY never sees a mid-burst underrun.
module rpc_wbuf_burst_drainer #(
  parameter int DataWidth  = 256,
  parameter int LenWidth   = 6,
  parameter int UsageWidth = 9
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  rpc_wbuf_burst_drainer_if.slave bus
);
  localparam int CntW = LenWidth + 1;
  localparam int CmpW = (UsageWidth > CntW) ? UsageWidth : CntW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STREAM,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CntW-1:0]      need_q, need_d;
  logic [CntW-1:0]      fetch_cnt_q, fetch_cnt_d;
  logic [CntW-1:0]      sent_cnt_q, sent_cnt_d;
  logic                 phy_valid_q, phy_valid_d;
  logic                 phy_last_q, phy_last_d;
  logic [DataWidth-1:0] phy_data_q, phy_data_d;

  logic            cmd_ready;
  logic            fifo_ready;
  logic            pop;
  logic            phy_hs;
  logic [CmpW-1:0] usage_ext;
  logic [CmpW-1:0] need_ext;

  assign usage_ext = CmpW'(bus.usage_i);
  assign need_ext  = CmpW'(need_q);

  always_comb begin
    state_d     = state_q;
    need_d      = need_q;
    fetch_cnt_d = fetch_cnt_q;
    sent_cnt_d  = sent_cnt_q;
    phy_valid_d = phy_valid_q;
    phy_last_d  = phy_last_q;
    phy_data_d  = phy_data_q;

    cmd_ready  = (state_q == ST_IDLE) && !rst_i;
    // Pop only while words remain and the output register will be free next edge.
    fifo_ready = (state_q == ST_STREAM) && !rst_i && (fetch_cnt_q != need_q) &&
                 (!phy_valid_q || bus.phy_ready_i);
    pop        = fifo_ready && bus.fifo_valid_i;
    phy_hs     = phy_valid_q && bus.phy_ready_i;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid_i && cmd_ready) begin
          need_d      = CntW'(bus.cmd_len_i) + CntW'(1);
          fetch_cnt_d = '0;
          sent_cnt_d  = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (usage_ext >= need_ext) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (pop) begin
          phy_valid_d = 1'b1;
          phy_data_d  = bus.fifo_data_i;
          phy_last_d  = (fetch_cnt_q + CntW'(1)) == need_q;
          fetch_cnt_d = fetch_cnt_q + CntW'(1);
        end else if (phy_hs) begin
          phy_valid_d = 1'b0;
          phy_last_d  = 1'b0;
        end
        if (phy_hs) begin
          sent_cnt_d = sent_cnt_q + CntW'(1);
          // The word being accepted is the need-th one: burst complete.
          if (sent_cnt_q == (need_q - CntW'(1))) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        phy_valid_d = 1'b0;
        phy_last_d  = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      need_q      <= '0;
      fetch_cnt_q <= '0;
      sent_cnt_q  <= '0;
      phy_valid_q <= 1'b0;
      phy_last_q  <= 1'b0;
      phy_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      need_q      <= need_d;
      fetch_cnt_q <= fetch_cnt_d;
      sent_cnt_q  <= sent_cnt_d;
      phy_valid_q <= phy_valid_d;
      phy_last_q  <= phy_last_d;
      phy_data_q  <= phy_data_d;
    end
  end

  assign bus.cmd_ready_o  = cmd_ready;
  assign bus.fifo_ready_o = fifo_ready;
  assign bus.phy_valid_o  = phy_valid_q;
  assign bus.phy_data_o   = phy_data_q;
  assign bus.phy_last_o   = phy_last_q;
  assign bus.busy_o       = (state_q != ST_IDLE);
  assign bus.done_o       = (state_q == ST_DONE);
endmodule

// File: tb/tb_rpc_wbuf_burst_drainer.sv
// Directed and randomized bursts against a burst-level model: the buffer holds
// a known word sequence and every burst must deliver exactly its first need words.
module tb_rpc_wbuf_burst_drainer;
  localparam int DW = 256;
  localparam int LW = 6;
  localparam int UW = 9;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  rpc_wbuf_burst_drainer_if #(.DataWidth(DW), .LenWidth(LW), .UsageWidth(UW)) bus ();

  rpc_wbuf_burst_drainer #(.DataWidth(DW), .LenWidth(LW), .UsageWidth(UW)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [DW-1:0] buf_words [0:63];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    cyc++;
    #1;
    chk("idle_cmd_ready", bus.cmd_ready_o, 1);
  endtask

  // Caller is positioned just after a negedge; this cycle presents the command.
  task automatic run_burst(input int len, input int vpct, input int rpct,
                           input bit ramp, input int rst_after);
    int need = len + 1;
    int pops = 0, beats = 0, ramp_cnt = 0;
    int first_pop = -1, first_valid = -1, first_hs = -1, last_hs = -1, done_cyc = -1, hit = -1;
    bit prev_stall = 1'b0, abort = 1'b0, pop, hs;
    logic [DW-1:0] prev_data, w;
    logic prev_last;

    for (int i = 0; i < 64; i++) begin
      w = '0;
      for (int j = 1; j < 8; j++) w[j*32 +: 32] = $urandom;
      w[31:0] = i;
      buf_words[i] = w;
    end

    bus.cmd_valid_i  = 1'b1;
    bus.cmd_len_i    = LW'(len);
    bus.usage_i      = ramp ? '0 : UW'(need);
    bus.fifo_valid_i = 1'b0;
    bus.phy_ready_i  = 1'b0;
    #1;
    chk("cmd_ready_idle", bus.cmd_ready_o, 1);
    chk("busy_idle", bus.busy_o, 0);

    for (int c = 0; c < 3000 && done_cyc < 0 && !abort; c++) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        chk("stall_valid", bus.phy_valid_o, 1);
        chk("stall_data", bus.phy_data_o, prev_data);
        chk("stall_last", bus.phy_last_o, prev_last);
      end
      if (bus.phy_valid_o && first_valid < 0) first_valid = cyc;
      chk("cmd_ready_busy", bus.cmd_ready_o, 0);
      chk("busy_active", bus.busy_o, 1);
      if (bus.done_o) begin
        done_cyc = cyc;
        chk("done_after_last", cyc, last_hs + 1);
        chk("done_valid_low", bus.phy_valid_o, 0);
        bus.cmd_valid_i  = 1'b0;
        bus.fifo_valid_i = 1'b0;
        bus.phy_ready_i  = 1'b0;
      end else begin
        // Stray commands while busy must be ignored.
        bus.cmd_valid_i = 1'($urandom_range(0, 1));
        bus.cmd_len_i   = LW'($urandom);
        if (ramp) begin
          bus.usage_i = UW'((ramp_cnt < need) ? ramp_cnt : need);
          if (ramp_cnt >= need && hit < 0) hit = cyc;
          ramp_cnt++;
        end
        bus.fifo_valid_i = ($urandom_range(0, 99) < vpct);
        bus.phy_ready_i  = ($urandom_range(0, 99) < rpct);
        bus.fifo_data_i  = (pops < 64) ? buf_words[pops] : '0;
        #1;
        pop = bus.fifo_valid_i && bus.fifo_ready_o;
        hs  = bus.phy_valid_o && bus.phy_ready_i;
        prev_stall = bus.phy_valid_o && !bus.phy_ready_i;
        prev_data  = bus.phy_data_o;
        prev_last  = bus.phy_last_o;
        if (pop) begin
          if (first_pop < 0) first_pop = cyc;
          pops++;
          chk("pop_bound", (pops <= need), 1);
        end
        if (hs) begin
          chk("beat_data", bus.phy_data_o, (beats < 64) ? buf_words[beats] : '0);
          chk("beat_last", bus.phy_last_o, (beats == need - 1));
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
          beats++;
          if (rst_after > 0 && beats == rst_after) abort = 1'b1;
        end
      end
    end

    if (abort) begin
      @(negedge clk);
      cyc++;
      rst_i            = 1'b1;
      bus.cmd_valid_i  = 1'b0;
      bus.fifo_valid_i = 1'b1;
      bus.phy_ready_i  = 1'b1;
      #1;
      chk("rst_cmd_ready", bus.cmd_ready_o, 0);
      chk("rst_fifo_ready", bus.fifo_ready_o, 0);
      @(negedge clk);
      cyc++;
      rst_i = 1'b0;
      bus.fifo_valid_i = 1'b0;
      #1;
      chk("abort_phy_valid", bus.phy_valid_o, 0);
      chk("abort_busy", bus.busy_o, 0);
      chk("abort_fifo_ready", bus.fifo_ready_o, 0);
      chk("abort_phy_last", bus.phy_last_o, 0);
      chk("abort_phy_data", bus.phy_data_o, '0);
      chk("abort_cmd_ready", bus.cmd_ready_o, 1);
    end else begin
      chk("done_seen", (done_cyc >= 0), 1);
      chk("beat_count", beats, need);
      chk("pop_count", pops, need);
      chk("first_valid_latency", first_valid, first_pop + 1);
      if (ramp) chk("first_pop_after_hit", first_pop, hit + 1);
      if (vpct == 100 && rpct == 100) chk("contiguous", last_hs - first_hs, need - 1);
      @(negedge clk);
      cyc++;
      #1;
      chk("done_single", bus.done_o, 0);
      chk("post_cmd_ready", bus.cmd_ready_o, 1);
      chk("post_busy", bus.busy_o, 0);
      chk("post_phy_valid", bus.phy_valid_o, 0);
    end
    $display("burst len=%0d need=%0d beats=%0d pops=%0d done_cycle=%0d abort=%0d",
             len, need, beats, pops, done_cyc, abort);
  endtask

  initial begin
    rst_i            = 1'b1;
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_len_i    = '0;
    bus.usage_i      = '0;
    bus.fifo_valid_i = 1'b0;
    bus.fifo_data_i  = '0;
    bus.phy_ready_i  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_cmd_ready", bus.cmd_ready_o, 0);
    chk("reset_phy_valid", bus.phy_valid_o, 0);
    chk("reset_phy_last", bus.phy_last_o, 0);
    chk("reset_phy_data", bus.phy_data_o, '0);
    chk("reset_busy", bus.busy_o, 0);
    chk("reset_done", bus.done_o, 0);
    chk("reset_fifo_ready", bus.fifo_ready_o, 0);
    @(negedge clk);
    cyc++;
    rst_i = 1'b0;
    #1;
    chk("post_reset_cmd_ready", bus.cmd_ready_o, 1);

    run_burst(3, 100, 100, 1'b0, 0);
    idle_cycle();
    run_burst(7, 100, 100, 1'b1, 0);
    idle_cycle();
    run_burst(0, 100, 100, 1'b0, 0);
    idle_cycle();
    run_burst(63, 70, 50, 1'b0, 0);
    idle_cycle();
    run_burst(1, 100, 100, 1'b0, 0);
    run_burst(2, 100, 100, 1'b0, 0);
    idle_cycle();
    run_burst(31, 100, 100, 1'b0, 10);
    run_burst(31, 80, 80, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      idle_cycle();
      run_burst($urandom_range(0, 63), $urandom_range(30, 90), $urandom_range(30, 90), 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
